or1200_wbqueue: RTL and testbench

Write-back queue between the dual-issue write-back mux and the single-write-port register file. Each cycle it accepts up to two register writes, one from pipe 1 and one from pipe 2, taken from the wbmux outputs `muxout` and `muxout2`. It drains one write per cycle to the RF in program order. It also supplies a bypass lookup so that operand muxes see results that are still pending.

---
 rtl/or1200_wbqueue.sv | 121 ++++++++++++
 tb/tb_or1200_wbqueue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/or1200_wbqueue.sv
// or1200_wbqueue
// Write-back queue that sits between the dual-issue write-back mux and a
// register file with a single write port. It accepts up to two writes per
// cycle and drains one per cycle in program order. It also provides a bypass
// lookup over the pending entries.
//
// Ports
//   clk, rst                 clock; synchronous active-low reset
//   wb_freeze                blocks enqueue
//   we1/waddr1/wdata1        pipe-1 (older) write
//   we2/waddr2/wdata2        pipe-2 (younger) write
//   rf_busy                  RF port unavailable; holds the head entry
//   stall                    fewer than two free entries
//   rf_we/rf_addr/rf_data    RF write port (head entry; zero when empty)
//   byp_addr/byp_hit/byp_data  bypass lookup of the youngest pending match
//   count                    occupied entries
module or1200_wbqueue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_freeze,
  input  logic                     we1,
  input  logic [AW-1:0]            waddr1,
  input  logic [DW-1:0]            wdata1,
  input  logic                     we2,
  input  logic [AW-1:0]            waddr2,
  input  logic [DW-1:0]            wdata2,
  input  logic                     rf_busy,
  output logic                     stall,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_addr,
  output logic [DW-1:0]            rf_data,
  input  logic [AW-1:0]            byp_addr,
  output logic                     byp_hit,
  output logic [DW-1:0]            byp_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] STALL_AT = CW'(DEPTH - 1);

  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  logic          acc;
  logic          v1;
  logic          v2;
  logic          pop;
  logic [CW-1:0] n_enq;
  logic [CW-1:0] n_pop;
  logic [PW-1:0] tail2;
  logic [PW-1:0] idx;

  // stall is decoded from the registered count only, so there is no
  // combinational path from the write requests.
  assign stall = (count >= STALL_AT);
  assign acc   = !wb_freeze && !stall;
  assign pop   = (count != '0) && !rf_busy;
  assign rf_we = pop;

  // r0 writes are dropped; when both pipes hit the same register the older
  // pipe-1 write is dead and is dropped as well.
  always_comb begin
    v1 = acc && we1 && (waddr1 != '0);
    v2 = acc && we2 && (waddr2 != '0);
    if (v1 && v2 && (waddr1 == waddr2)) v1 = 1'b0;
  end

  assign n_enq = {{PW{1'b0}}, v1} + {{PW{1'b0}}, v2};
  assign n_pop = {{PW{1'b0}}, pop};
  assign tail2 = v1 ? tail + PW'(1) : tail;

  // Storage is not reset; every output is masked by count.
  always_ff @(posedge clk) begin
    if (v1) begin
      mem_addr[tail] <= waddr1;
      mem_data[tail] <= wdata1;
    end
    if (v2) begin
      mem_addr[tail2] <= waddr2;
      mem_data[tail2] <= wdata2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + n_enq[PW-1:0];
      count <= count + n_enq - n_pop;
    end
  end

  assign rf_addr = (count != '0) ? mem_addr[head] : '0;
  assign rf_data = (count != '0) ? mem_data[head] : '0;

  // Scan from oldest to youngest so the last match wins. The head entry that
  // is being popped this cycle is still visible here.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (byp_addr != '0) && (mem_addr[idx] == byp_addr)) begin
        byp_hit  = 1'b1;
        byp_data = mem_data[idx];
      end
    end
  end

endmodule

// File: tb/tb_or1200_wbqueue.sv
module tb_or1200_wbqueue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_freeze;
  logic          we1;
  logic [AW-1:0] waddr1;
  logic [DW-1:0] wdata1;
  logic          we2;
  logic [AW-1:0] waddr2;
  logic [DW-1:0] wdata2;
  logic          rf_busy;
  logic          stall;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic [AW-1:0] byp_addr;
  logic          byp_hit;
  logic [DW-1:0] byp_data;
  logic [2:0]    count;

  or1200_wbqueue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .wb_freeze(wb_freeze),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .we2(we2), .waddr2(waddr2), .wdata2(wdata2),
    .rf_busy(rf_busy), .stall(stall),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .byp_addr(byp_addr), .byp_hit(byp_hit), .byp_data(byp_data),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        fz;
    logic        w1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        w2;
    logic [4:0]  a2;
    logic [31:0] d2;
    logic        busy;
    logic [4:0]  ba;
    logic        e_stall;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_hit;
    logic [31:0] e_bd;
    logic [2:0]  e_cnt;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  int   total = 0;
  int   bad   = 0;
  vec_t tbl [19];
  ent_t q [$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic fz, input logic w1, input logic [4:0] a1,
                       input logic [31:0] d1, input logic w2, input logic [4:0] a2,
                       input logic [31:0] d2, input logic busy, input logic [4:0] ba);
    rst = r; wb_freeze = fz; we1 = w1; waddr1 = a1; wdata1 = d1;
    we2 = w2; waddr2 = a2; wdata2 = d2; rf_busy = busy; byp_addr = ba;
  endtask

  task automatic check(input string n, input logic e_stall, input logic e_we,
                       input logic [4:0] e_addr, input logic [31:0] e_data,
                       input logic e_hit, input logic [31:0] e_bd, input logic [2:0] e_cnt);
    chk({n, ".stall"},    {31'b0, stall},   {31'b0, e_stall});
    chk({n, ".rf_we"},    {31'b0, rf_we},   {31'b0, e_we});
    chk({n, ".rf_addr"},  {27'b0, rf_addr}, {27'b0, e_addr});
    chk({n, ".rf_data"},  rf_data,          e_data);
    chk({n, ".byp_hit"},  {31'b0, byp_hit}, {31'b0, e_hit});
    chk({n, ".byp_data"}, byp_data,         e_bd);
    chk({n, ".count"},    {29'b0, count},   {29'b0, e_cnt});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        r, fz, w1, w2, busy;
    logic [4:0]  a1, a2, ba;
    logic [31:0] d1, d2;
    logic        e_stall, e_we, e_hit, s1, s2;
    logic [4:0]  e_addr;
    logic [31:0] e_data, e_bd;
    logic [4:0]  t4_addr [4];
    logic [2:0]  t4_cnt [4];
    logic        t4_stall [4];

    //            r  fz w1 a1 d1            w2 a2 d2            bsy ba  | stl we addr data          hit bd            cnt
    tbl[0]  = '{0, 0, 1, 3, 32'h12345678, 1, 5, 32'h90ABCDEF, 0, 3,   0, 0, 0, 32'h0,        0, 32'h0,        0};
    tbl[1]  = '{0, 0, 1, 3, 32'h12345678, 1, 5, 32'h90ABCDEF, 0, 5,   0, 0, 0, 32'h0,        0, 32'h0,        0};
    tbl[2]  = '{1, 0, 1, 3, 32'h12345678, 1, 5, 32'h90ABCDEF, 0, 0,   0, 0, 0, 32'h0,        0, 32'h0,        0};
    tbl[3]  = '{1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 5,   0, 1, 3, 32'h12345678, 1, 32'h90ABCDEF, 2};
    tbl[4]  = '{1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 3,   0, 1, 5, 32'h90ABCDEF, 0, 32'h0,        1};
    tbl[5]  = '{1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 5,   0, 0, 0, 32'h0,        0, 32'h0,        0};
    tbl[6]  = '{1, 0, 1, 7, 32'h23456789, 1, 7, 32'h0ABCDEF9, 1, 7,   0, 0, 0, 32'h0,        0, 32'h0,        0};
    tbl[7]  = '{1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 7,   0, 0, 7, 32'h0ABCDEF9, 1, 32'h0ABCDEF9, 1};
    tbl[8]  = '{1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 7,   0, 1, 7, 32'h0ABCDEF9, 1, 32'h0ABCDEF9, 1};
    tbl[9]  = '{1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 7,   0, 0, 0, 32'h0,        0, 32'h0,        0};
    tbl[10] = '{1, 1, 1, 11, 32'h11,      1, 12, 32'h22,      1, 11,  0, 0, 0, 32'h0,        0, 32'h0,        0};
    tbl[11] = '{1, 0, 1, 0, 32'hDEAD,     1, 9, 32'h34567890, 1, 9,   0, 0, 0, 32'h0,        0, 32'h0,        0};
    tbl[12] = '{1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 9,   0, 0, 9, 32'h34567890, 1, 32'h34567890, 1};
    tbl[13] = '{1, 0, 1, 9, 32'h4567890A, 0, 0, 32'h0,        1, 9,   0, 0, 9, 32'h34567890, 1, 32'h34567890, 1};
    tbl[14] = '{1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 9,   0, 0, 9, 32'h34567890, 1, 32'h4567890A, 2};
    tbl[15] = '{1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0,   0, 0, 9, 32'h34567890, 0, 32'h0,        2};
    tbl[16] = '{1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 9,   0, 1, 9, 32'h34567890, 1, 32'h4567890A, 2};
    tbl[17] = '{1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 9,   0, 1, 9, 32'h4567890A, 1, 32'h4567890A, 1};
    tbl[18] = '{1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 9,   0, 0, 0, 32'h0,        0, 32'h0,        0};

    drive(0, 0, 1, 3, 32'h12345678, 1, 5, 32'h90ABCDEF, 0, 0);
    tick();

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].r, tbl[i].fz, tbl[i].w1, tbl[i].a1, tbl[i].d1,
            tbl[i].w2, tbl[i].a2, tbl[i].d2, tbl[i].busy, tbl[i].ba);
      #4;
      check($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_we, tbl[i].e_addr,
            tbl[i].e_data, tbl[i].e_hit, tbl[i].e_bd, tbl[i].e_cnt);
      tick();
    end

    // Fill while the RF is busy, then try to push past full.
    drive(1, 0, 1, 1, 32'h101, 1, 2, 32'h102, 1, 0);
    #4; check("full_a", 0, 0, 0, 32'h0, 0, 32'h0, 0); tick();
    drive(1, 0, 1, 4, 32'h104, 1, 6, 32'h106, 1, 0);
    #4; check("full_b", 0, 0, 1, 32'h101, 0, 32'h0, 2); tick();
    drive(1, 0, 1, 8, 32'h108, 1, 10, 32'h10A, 1, 0);
    #4; check("full_c", 1, 0, 1, 32'h101, 0, 32'h0, 4); tick();
    #4; check("full_d", 1, 0, 1, 32'h101, 0, 32'h0, 4); tick();
    t4_addr  = '{5'd1, 5'd2, 5'd4, 5'd6};
    t4_cnt   = '{3'd4, 3'd3, 3'd2, 3'd1};
    t4_stall = '{1'b1, 1'b1, 1'b0, 1'b0};
    drive(1, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #4;
      check($sformatf("drain%0d", i), t4_stall[i], 1, t4_addr[i],
            32'h100 | {27'b0, t4_addr[i]}, 0, 32'h0, t4_cnt[i]);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      #4; check($sformatf("drained%0d", i), 0, 0, 0, 32'h0, 0, 32'h0, 0); tick();
    end

    // Reset with three entries pending and the RF ready.
    drive(1, 0, 1, 13, 32'h13, 1, 14, 32'h14, 1, 0);
    #4; check("rstmid_a", 0, 0, 0, 32'h0, 0, 32'h0, 0); tick();
    drive(1, 0, 1, 15, 32'h15, 0, 0, 32'h0, 1, 0);
    #4; check("rstmid_b", 0, 0, 13, 32'h13, 0, 32'h0, 2); tick();
    drive(0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 14);
    #4; check("rstmid_c", 1, 1, 13, 32'h13, 1, 32'h14, 3); tick();
    drive(1, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 14);
    for (int i = 0; i < 3; i++) begin
      #4; check($sformatf("rstmid_after%0d", i), 0, 0, 0, 32'h0, 0, 32'h0, 0); tick();
    end

    // Random traffic against an in-order queue model.
    q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r    = ($urandom_range(0, 63) != 0);
      fz   = ($urandom_range(0, 7) == 0);
      w1   = $urandom_range(0, 1) == 1;
      w2   = $urandom_range(0, 1) == 1;
      a1   = 5'($urandom_range(0, 7));
      a2   = 5'($urandom_range(0, 7));
      d1   = $urandom;
      d2   = $urandom;
      busy = ($urandom_range(0, 2) == 0);
      ba   = 5'($urandom_range(0, 7));
      drive(r, fz, w1, a1, d1, w2, a2, d2, busy, ba);

      e_stall = (DEPTH - q.size()) < 2;
      e_we    = (q.size() != 0) && !busy;
      e_addr  = (q.size() != 0) ? q[0].a : 5'd0;
      e_data  = (q.size() != 0) ? q[0].d : 32'd0;
      e_hit   = 1'b0;
      e_bd    = 32'd0;
      for (int k = q.size() - 1; k >= 0; k--) begin
        if (!e_hit && ba != 0 && q[k].a == ba) begin
          e_hit = 1'b1;
          e_bd  = q[k].d;
        end
      end
      #4;
      check("rnd", e_stall, e_we, e_addr, e_data, e_hit, e_bd, 3'(q.size()));
      tick();

      if (!r) begin
        q.delete();
      end else begin
        if (e_we) void'(q.pop_front());
        if (!fz && !e_stall) begin
          s1 = w1 && a1 != 0;
          s2 = w2 && a2 != 0;
          if (s1 && s2 && a1 == a2) s1 = 1'b0;
          if (s1) q.push_back('{a1, d1});
          if (s2) q.push_back('{a2, d2});
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
